// File: rtl/cms_multi_range_trace_trigger_pkg.sv
// rtl/cms_multi_range_trace_trigger_pkg.sv - shared types and register map for the multi-range trace trigger
package cms_multi_range_trace_trigger_pkg;

    localparam int DEF_NUM_RANGES     = 4;
    localparam int DEF_TRIG_CNT_WIDTH = 16;

    typedef enum logic [7:0] {
        ADDR_START_EN   = 8'h00,
        ADDR_END_EN     = 8'h01,
        ADDR_START_ADDR = 8'h02,
        ADDR_END_ADDR   = 8'h03,
        ADDR_MODE       = 8'h04,
        ADDR_ARM        = 8'h05,
        ADDR_DISARM     = 8'h06,
        ADDR_STATUS     = 8'h07,
        ADDR_RANGE_BASE = 8'h20
    } ctrl_addr_t;

    localparam int RANGE_STRIDE = 4;
    localparam int RANGE_LO     = 0;
    localparam int RANGE_HI     = 1;
    localparam int RANGE_FLAGS  = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_TRACING = 2'd2,
        ST_DONE    = 2'd3
    } trigger_state_t;

    // Field order matches the flags register: bit3 ch_en .. bit0 lo_en.
    typedef struct packed {
        logic ch_en;
        logic invert;
        logic hi_en;
        logic lo_en;
    } range_flags_t;

    function automatic logic [7:0] range_addr(input int ch, input int off);
        return 8'(int'(ADDR_RANGE_BASE) + RANGE_STRIDE * ch + off);
    endfunction

endpackage

// File: rtl/cms_range_comparator.sv
// rtl/cms_range_comparator.sv - one PC-range channel: inclusive unsigned bounds with enables and invert
module cms_range_comparator
    import cms_multi_range_trace_trigger_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] hi,
    input  range_flags_t    flags,
    output logic            hit
);

    logic above_lo;
    logic below_hi;
    logic raw;

    assign above_lo = !flags.lo_en || (pc >= lo);
    assign below_hi = !flags.hi_en || (pc <= hi);
    assign raw      = above_lo && below_hi;
    assign hit      = flags.ch_en && (raw ^ flags.invert);

endmodule

// File: rtl/cms_multi_range_trace_trigger.sv
// rtl/cms_multi_range_trace_trigger.sv - arm/trace/stop window controller with NUM_RANGES PC-range filter channels
module cms_multi_range_trace_trigger
    import cms_multi_range_trace_trigger_pkg::*;
#(
    parameter int NUM_RANGES      = DEF_NUM_RANGES,
    parameter int XLEN            = 64,
    parameter int CTRL_ADDR_WIDTH = 8,
    parameter int CTRL_DATA_WIDTH = 64,
    parameter int TRIG_CNT_WIDTH  = DEF_TRIG_CNT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ctrl_wr_en,
    input  logic [CTRL_ADDR_WIDTH-1:0] ctrl_addr,
    input  logic [CTRL_DATA_WIDTH-1:0] ctrl_wdata,
    output logic [CTRL_DATA_WIDTH-1:0] ctrl_rdata,
    input  logic                       in_valid,
    input  logic [XLEN-1:0]            in_pc,
    output logic                       out_valid,
    output logic [XLEN-1:0]            out_pc,
    output logic                       trace_active,
    output logic [NUM_RANGES-1:0]      range_hit,
    output logic [TRIG_CNT_WIDTH-1:0]  trig_count
);

    function automatic logic addr_is(input logic [CTRL_ADDR_WIDTH-1:0] a, input logic [7:0] code);
        return a == CTRL_ADDR_WIDTH'(code);
    endfunction

    logic                  start_en;
    logic                  end_en;
    logic                  repeat_mode;
    logic [XLEN-1:0]       start_addr;
    logic [XLEN-1:0]       end_addr;
    logic [XLEN-1:0]       lo_bound [NUM_RANGES];
    logic [XLEN-1:0]       hi_bound [NUM_RANGES];
    range_flags_t          flags    [NUM_RANGES];
    logic [NUM_RANGES-1:0] hit;
    logic [NUM_RANGES-1:0] ch_en_vec;

    trigger_state_t        state;
    trigger_state_t        next_state;
    logic                  start_evt;
    logic                  wr_arm;
    logic                  wr_disarm;
    logic                  start_hit;
    logic                  end_hit;
    logic                  in_window;
    logic                  range_ok;
    logic [CTRL_DATA_WIDTH-1:0] rdata_next;

    for (genvar g = 0; g < NUM_RANGES; g++) begin : g_ch
        cms_range_comparator #(.XLEN(XLEN)) u_cmp (
            .pc    (in_pc),
            .lo    (lo_bound[g]),
            .hi    (hi_bound[g]),
            .flags (flags[g]),
            .hit   (hit[g])
        );
        assign ch_en_vec[g] = flags[g].ch_en;
    end

    // With no channel enabled the range filter is transparent.
    assign range_ok  = (|ch_en_vec) ? (|hit) : 1'b1;
    assign wr_arm    = ctrl_wr_en && addr_is(ctrl_addr, ADDR_ARM);
    assign wr_disarm = ctrl_wr_en && addr_is(ctrl_addr, ADDR_DISARM);
    assign start_hit = in_valid && (in_pc == start_addr);
    assign end_hit   = in_valid && end_en && (in_pc == end_addr);
    // Window is judged on the pre-command state; the start instruction is in-window.
    assign in_window = (state == ST_TRACING) || ((state == ST_ARMED) && start_hit);
    assign trace_active = (state == ST_TRACING);

    always_comb begin
        next_state = state;
        start_evt  = 1'b0;
        if (wr_disarm) begin
            next_state = ST_IDLE;
        end else if (wr_arm) begin
            if (start_en) begin
                next_state = ST_ARMED;
            end else begin
                next_state = ST_TRACING;
                start_evt  = 1'b1;
            end
        end else begin
            case (state)
                ST_ARMED: if (start_hit) begin
                    next_state = ST_TRACING;
                    start_evt  = 1'b1;
                end
                ST_TRACING: if (end_hit) begin
                    next_state = repeat_mode ? ST_ARMED : ST_DONE;
                end
                default: next_state = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            trig_count <= '0;
            out_valid  <= 1'b0;
            out_pc     <= '0;
            range_hit  <= '0;
        end else begin
            state     <= next_state;
            out_valid <= in_valid && in_window && range_ok;
            out_pc    <= in_pc;
            if (in_valid) begin
                range_hit <= hit;
            end
            if (start_evt && (trig_count != {TRIG_CNT_WIDTH{1'b1}})) begin
                trig_count <= trig_count + TRIG_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_en    <= 1'b0;
            end_en      <= 1'b0;
            repeat_mode <= 1'b0;
            start_addr  <= '0;
            end_addr    <= '0;
            for (int i = 0; i < NUM_RANGES; i++) begin
                lo_bound[i] <= '0;
                hi_bound[i] <= '0;
                flags[i]    <= '0;
            end
        end else if (ctrl_wr_en) begin
            if (addr_is(ctrl_addr, ADDR_START_EN))   start_en    <= ctrl_wdata[0];
            if (addr_is(ctrl_addr, ADDR_END_EN))     end_en      <= ctrl_wdata[0];
            if (addr_is(ctrl_addr, ADDR_START_ADDR)) start_addr  <= XLEN'(ctrl_wdata);
            if (addr_is(ctrl_addr, ADDR_END_ADDR))   end_addr    <= XLEN'(ctrl_wdata);
            if (addr_is(ctrl_addr, ADDR_MODE))       repeat_mode <= ctrl_wdata[0];
            for (int i = 0; i < NUM_RANGES; i++) begin
                if (addr_is(ctrl_addr, range_addr(i, RANGE_LO)))    lo_bound[i] <= XLEN'(ctrl_wdata);
                if (addr_is(ctrl_addr, range_addr(i, RANGE_HI)))    hi_bound[i] <= XLEN'(ctrl_wdata);
                if (addr_is(ctrl_addr, range_addr(i, RANGE_FLAGS))) flags[i]    <= range_flags_t'(ctrl_wdata[3:0]);
            end
        end
    end

    always_comb begin
        rdata_next = '0;
        if (addr_is(ctrl_addr, ADDR_START_EN))   rdata_next[0] = start_en;
        if (addr_is(ctrl_addr, ADDR_END_EN))     rdata_next[0] = end_en;
        if (addr_is(ctrl_addr, ADDR_START_ADDR)) rdata_next    = CTRL_DATA_WIDTH'(start_addr);
        if (addr_is(ctrl_addr, ADDR_END_ADDR))   rdata_next    = CTRL_DATA_WIDTH'(end_addr);
        if (addr_is(ctrl_addr, ADDR_MODE))       rdata_next[0] = repeat_mode;
        if (addr_is(ctrl_addr, ADDR_STATUS)) begin
            rdata_next[1:0]                 = state;
            rdata_next[16 +: TRIG_CNT_WIDTH] = trig_count;
        end
        for (int i = 0; i < NUM_RANGES; i++) begin
            if (addr_is(ctrl_addr, range_addr(i, RANGE_LO)))    rdata_next      = CTRL_DATA_WIDTH'(lo_bound[i]);
            if (addr_is(ctrl_addr, range_addr(i, RANGE_HI)))    rdata_next      = CTRL_DATA_WIDTH'(hi_bound[i]);
            if (addr_is(ctrl_addr, range_addr(i, RANGE_FLAGS))) rdata_next[3:0] = flags[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_rdata <= '0;
        end else begin
            ctrl_rdata <= rdata_next;
        end
    end

endmodule

// File: tb/tb_cms_multi_range_trace_trigger.sv
// tb/tb_cms_multi_range_trace_trigger.sv - directed self-checking bench for the multi-range trace trigger
module tb_cms_multi_range_trace_trigger;

    localparam int NR  = 4;
    localparam int XL  = 64;
    localparam int AW  = 8;
    localparam int DW  = 64;
    localparam int TCW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ctrl_wr_en = 1'b0;
    logic [AW-1:0] ctrl_addr = '0;
    logic [DW-1:0] ctrl_wdata = '0;
    logic [DW-1:0] ctrl_rdata;
    logic          in_valid = 1'b0;
    logic [XL-1:0] in_pc = '0;
    logic          out_valid;
    logic [XL-1:0] out_pc;
    logic          trace_active;
    logic [NR-1:0] range_hit;
    logic [TCW-1:0] trig_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cms_multi_range_trace_trigger #(
        .NUM_RANGES(NR), .XLEN(XL), .CTRL_ADDR_WIDTH(AW),
        .CTRL_DATA_WIDTH(DW), .TRIG_CNT_WIDTH(TCW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ctrl_wr_en(ctrl_wr_en), .ctrl_addr(ctrl_addr),
        .ctrl_wdata(ctrl_wdata), .ctrl_rdata(ctrl_rdata), .in_valid(in_valid),
        .in_pc(in_pc), .out_valid(out_valid), .out_pc(out_pc),
        .trace_active(trace_active), .range_hit(range_hit), .trig_count(trig_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [63:0] d);
        ctrl_wr_en = 1'b1;
        ctrl_addr  = a;
        ctrl_wdata = d;
        step();
        ctrl_wr_en = 1'b0;
        ctrl_wdata = '0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [63:0] d);
        ctrl_addr = a;
        step();
        d = ctrl_rdata;
    endtask

    task automatic instr(input logic [63:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_pc = '0;
        ctrl_wr_en = 1'b0;
        ctrl_addr = '0;
        ctrl_wdata = '0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        logic [63:0] d;
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || trace_active !== 1'b0 || trig_count !== '0 || range_hit !== '0 || out_pc !== '0) begin
            failures++;
            $display("FAIL reset_outputs got ov=%b ta=%b tc=%0h rh=%b pc=%0h exp all 0",
                     out_valid, trace_active, trig_count, range_hit, out_pc);
        end
        for (int a = 0; a < 8'h30; a++) begin
            rd(8'(a), d);
            checks++;
            if (d !== 64'h0) begin
                failures++;
                $display("FAIL reset_read addr=%0h got=%0h exp=0", a, d);
            end
        end
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_pc = 64'(i * 4);
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL idle_no_pass cycle=%0d got=%b exp=0", i, out_valid);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_single_window();
        logic [63:0] d;
        logic [63:0] pcs [5] = '{64'h0F00, 64'h1000, 64'h1050, 64'h1100, 64'h1200};
        logic [4:0] pass = 5'b01110;
        wr(8'h00, 64'h1);
        wr(8'h02, 64'h1000);
        wr(8'h01, 64'h1);
        wr(8'h03, 64'h1100);
        wr(8'h05, 64'h0);
        rd(8'h07, d);
        checks++;
        if (d !== 64'h1) begin
            failures++;
            $display("FAIL single_armed_status got=%0h exp=1", d);
        end
        for (int i = 0; i < 5; i++) begin
            instr(pcs[i]);
            checks++;
            if (out_valid !== pass[4-i] || (pass[4-i] && out_pc !== pcs[i])) begin
                failures++;
                $display("FAIL single_window pc=%0h got ov=%b opc=%0h exp ov=%b", pcs[i], out_valid, out_pc, pass[4-i]);
            end
        end
        rd(8'h07, d);
        checks++;
        if (d !== (64'h3 | (64'h1 << 16)) || trig_count !== 4'd1) begin
            failures++;
            $display("FAIL single_done_status got=%0h tc=%0d exp=%0h tc=1", d, trig_count, 64'h3 | (64'h1 << 16));
        end
    endtask

    task automatic test_repeat();
        logic [63:0] d;
        logic [63:0] pcs [5] = '{64'h0F00, 64'h1000, 64'h1050, 64'h1100, 64'h1200};
        logic [4:0] pass = 5'b01110;
        do_reset();
        wr(8'h00, 64'h1);
        wr(8'h02, 64'h1000);
        wr(8'h01, 64'h1);
        wr(8'h03, 64'h1100);
        wr(8'h04, 64'h1);
        wr(8'h05, 64'h0);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 5; i++) begin
                instr(pcs[i]);
                checks++;
                if (out_valid !== pass[4-i]) begin
                    failures++;
                    $display("FAIL repeat_window round=%0d pc=%0h got=%b exp=%b", r, pcs[i], out_valid, pass[4-i]);
                end
            end
        end
        rd(8'h07, d);
        checks++;
        if (d !== (64'h1 | (64'h2 << 16)) || trig_count !== 4'd2) begin
            failures++;
            $display("FAIL repeat_status got=%0h tc=%0d exp=%0h tc=2", d, trig_count, 64'h1 | (64'h2 << 16));
        end
    endtask

    task automatic test_ranges();
        logic [63:0] d;
        logic [63:0] pcs [4] = '{64'h1FFF, 64'h2000, 64'h2FFF, 64'h3000};
        logic [3:0] hits [4] = '{4'b0010, 4'b0001, 4'b0001, 4'b0010};
        do_reset();
        wr(8'h20, 64'h2000);
        wr(8'h21, 64'h2FFF);
        wr(8'h22, 64'hB);
        wr(8'h24, 64'h2000);
        wr(8'h25, 64'h2FFF);
        wr(8'h26, 64'hF);
        wr(8'h05, 64'h0);
        checks++;
        if (trace_active !== 1'b1 || trig_count !== 4'd1) begin
            failures++;
            $display("FAIL direct_arm got ta=%b tc=%0d exp ta=1 tc=1", trace_active, trig_count);
        end
        for (int i = 0; i < 4; i++) begin
            instr(pcs[i]);
            checks++;
            if (range_hit !== hits[i] || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL range_hit pc=%0h got rh=%b ov=%b exp rh=%b ov=1", pcs[i], range_hit, out_valid, hits[i]);
            end
        end
        rd(8'h26, d);
        checks++;
        if (d !== 64'hF) begin
            failures++;
            $display("FAIL flags_read got=%0h exp=f", d);
        end
        rd(8'h21, d);
        checks++;
        if (d !== 64'h2FFF) begin
            failures++;
            $display("FAIL hi_read got=%0h exp=2fff", d);
        end
        wr(8'h26, 64'h7);
        instr(64'h3000);
        checks++;
        if (range_hit !== 4'b0000 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL range_block got rh=%b ov=%b exp rh=0000 ov=0", range_hit, out_valid);
        end
        // Disable ch0 in the same cycle as an out-of-range instruction: old config applies.
        ctrl_wr_en = 1'b1;
        ctrl_addr = 8'h22;
        ctrl_wdata = 64'h0;
        in_valid = 1'b1;
        in_pc = 64'h3000;
        step();
        ctrl_wr_en = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL cfg_same_cycle got=%b exp=0", out_valid);
        end
        instr(64'h3000);
        checks++;
        if (out_valid !== 1'b1 || range_hit !== 4'b0000) begin
            failures++;
            $display("FAIL cfg_next_cycle got ov=%b rh=%b exp ov=1 rh=0000", out_valid, range_hit);
        end
    endtask

    task automatic test_same_addr();
        logic [63:0] d;
        do_reset();
        wr(8'h00, 64'h1);
        wr(8'h01, 64'h1);
        wr(8'h02, 64'h4000);
        wr(8'h03, 64'h4000);
        wr(8'h05, 64'h0);
        instr(64'h4000);
        checks++;
        if (out_valid !== 1'b1 || trace_active !== 1'b1) begin
            failures++;
            $display("FAIL same_addr_start got ov=%b ta=%b exp ov=1 ta=1", out_valid, trace_active);
        end
        instr(64'h4000);
        checks++;
        if (out_valid !== 1'b1 || trace_active !== 1'b0) begin
            failures++;
            $display("FAIL same_addr_end got ov=%b ta=%b exp ov=1 ta=0", out_valid, trace_active);
        end
        rd(8'h07, d);
        checks++;
        if (d !== (64'h3 | (64'h1 << 16))) begin
            failures++;
            $display("FAIL same_addr_status got=%0h exp=%0h", d, 64'h3 | (64'h1 << 16));
        end
    endtask

    task automatic test_saturation_disarm();
        logic [63:0] d;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            wr(8'h05, 64'h0);
            if (i == 13) begin
                checks++;
                if (trig_count !== 4'd14) begin
                    failures++;
                    $display("FAIL count_14 got=%0d exp=14", trig_count);
                end
            end
        end
        rd(8'h07, d);
        checks++;
        if (d !== (64'h2 | (64'hF << 16)) || trig_count !== 4'd15) begin
            failures++;
            $display("FAIL count_saturate got=%0h tc=%0d exp=%0h tc=15", d, trig_count, 64'h2 | (64'hF << 16));
        end
        instr(64'h5000);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL tracing_pass got=%b exp=1", out_valid);
        end
        ctrl_wr_en = 1'b1;
        ctrl_addr = 8'h06;
        in_valid = 1'b1;
        in_pc = 64'h5004;
        step();
        ctrl_wr_en = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h5004 || trace_active !== 1'b0) begin
            failures++;
            $display("FAIL disarm_same_cycle got ov=%b pc=%0h ta=%b exp ov=1 pc=5004 ta=0", out_valid, out_pc, trace_active);
        end
        in_pc = 64'h5008;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL disarm_drop got=%b exp=0", out_valid);
        end
        rd(8'h07, d);
        checks++;
        if (d !== (64'hF << 16)) begin
            failures++;
            $display("FAIL disarm_status got=%0h exp=%0h", d, 64'hF << 16);
        end
    endtask

    task automatic test_reset_mid_trace();
        wr(8'h05, 64'h0);
        in_valid = 1'b1;
        in_pc = 64'h6000;
        step();
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_pass got=%b exp=1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || trace_active !== 1'b0 || trig_count !== '0) begin
            failures++;
            $display("FAIL async_reset got ov=%b ta=%b tc=%0d exp 0", out_valid, trace_active, trig_count);
        end
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_window();
        test_repeat();
        test_ranges();
        test_same_addr();
        test_saturation_disarm();
        test_reset_mid_trace();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
